// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared MMIO peripheral constants: window base, timer register offsets, CTRL fields
package mmio_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

    localparam logic [1:0] TMR_CTRL   = 2'd0;
    localparam logic [1:0] TMR_LOAD   = 2'd1;
    localparam logic [1:0] TMR_COUNT  = 2'd2;
    localparam logic [1:0] TMR_STATUS = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_AUTO    = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int PRESCALE_LSB = 8;
    localparam int PRESCALE_MSB = 15;

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - 8-bit prescaler producing a one-cycle tick every prescale+1 enabled cycles
module timer_prescaler (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] prescale,
    output logic       tick
);

    logic [7:0] pcnt_q, pcnt_d;

    assign tick = en & (pcnt_q == prescale);

    always_comb begin
        pcnt_d = pcnt_q;
        if (clr) begin
            pcnt_d = '0;
        end else if (tick) begin
            pcnt_d = '0;
        end else if (en) begin
            pcnt_d = pcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - memory-mapped down-counting timer with prescaler, auto-reload and sticky expiry irq
module mmio_timer
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE = MMIO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        sel,
    output logic        irq
);

    logic        en_q, en_d;
    logic        auto_q, auto_d;
    logic        irq_en_q, irq_en_d;
    logic [7:0]  prescale_q, prescale_d;
    logic [31:0] load_q, load_d;
    logic [31:0] count_q, count_d;
    logic        expired_q, expired_d;

    logic [1:0]  off;
    logic        wr, wr_ctrl, wr_load, wr_count, wr_status;
    logic        tick, tick_eff, expire, pcnt_clr;
    logic        unused_bits;

    assign sel       = (DataAdr[31:4] == BASE[31:4]);
    assign off       = DataAdr[3:2];
    assign wr        = MemWrite & sel;
    assign wr_ctrl   = wr & (off == TMR_CTRL);
    assign wr_load   = wr & (off == TMR_LOAD);
    assign wr_count  = wr & (off == TMR_COUNT);
    assign wr_status = wr & (off == TMR_STATUS);

    // A bus write to COUNT/LOAD swallows any tick landing in the same cycle.
    assign tick_eff  = tick & ~(wr_load | wr_count);
    assign expire    = tick_eff & (count_q == 32'd0);
    assign pcnt_clr  = wr_load | wr_count | (wr_ctrl & WriteData[CTRL_EN] & ~en_q);
    assign irq       = expired_q & irq_en_q;

    assign unused_bits = ^{DataAdr[1:0], WriteData[31:16], WriteData[7:3]};

    timer_prescaler u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (en_q),
        .clr      (pcnt_clr),
        .prescale (prescale_q),
        .tick     (tick)
    );

    always_comb begin
        en_d       = en_q;
        auto_d     = auto_q;
        irq_en_d   = irq_en_q;
        prescale_d = prescale_q;
        load_d     = load_q;
        count_d    = count_q;
        expired_d  = expired_q;

        if (tick_eff) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else begin
                expired_d = 1'b1;
                if (auto_q) begin
                    count_d = load_q;
                end else begin
                    en_d = 1'b0;
                end
            end
        end

        // Bus writes come after the tick so they win for EN and COUNT.
        if (wr_ctrl) begin
            en_d       = WriteData[CTRL_EN];
            auto_d     = WriteData[CTRL_AUTO];
            irq_en_d   = WriteData[CTRL_IRQ_EN];
            prescale_d = WriteData[PRESCALE_MSB:PRESCALE_LSB];
        end
        if (wr_load) begin
            load_d  = WriteData;
            count_d = WriteData;
        end
        if (wr_count) begin
            count_d = WriteData;
        end
        if (wr_status && WriteData[0] && !expire) begin
            expired_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            prescale_q <= '0;
            load_q     <= '0;
            count_q    <= '0;
            expired_q  <= 1'b0;
        end else begin
            en_q       <= en_d;
            auto_q     <= auto_d;
            irq_en_q   <= irq_en_d;
            prescale_q <= prescale_d;
            load_q     <= load_d;
            count_q    <= count_d;
            expired_q  <= expired_d;
        end
    end

    always_comb begin
        ReadData = '0;
        if (sel) begin
            case (off)
                TMR_CTRL:   ReadData = {16'd0, prescale_q, 5'd0, irq_en_q, auto_q, en_q};
                TMR_LOAD:   ReadData = load_q;
                TMR_COUNT:  ReadData = count_q;
                TMR_STATUS: ReadData = {31'd0, expired_q};
                default:    ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// tb/tb_mmio_timer.sv - randomized self-checking bench for mmio_timer against a behavioural model
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        sel;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic        m_en, m_auto, m_ie, m_exp;
    logic [7:0]  m_ps;
    logic [31:0] m_load, m_count;
    int          m_pcnt;

    mmio_timer #(.BASE(BASE)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .sel       (sel),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [31:0] adr);
        logic [31:0] r;
        r = 32'd0;
        if (adr[31:4] == BASE[31:4]) begin
            case (adr[3:2])
                2'd0: r = {16'd0, m_ps, 5'd0, m_ie, m_auto, m_en};
                2'd1: r = m_load;
                2'd2: r = m_count;
                default: r = {31'd0, m_exp};
            endcase
        end
        return r;
    endfunction

    task automatic model_step(input logic we, input logic [31:0] adr, input logic [31:0] wd, input logic rst);
        logic wr, tick, lc_write, expire;
        if (rst) begin
            m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0; m_ps = 0;
            m_load = 0; m_count = 0; m_pcnt = 0;
            return;
        end
        wr       = we && (adr[31:4] == BASE[31:4]);
        lc_write = wr && (adr[3:2] == 2'd1 || adr[3:2] == 2'd2);
        tick     = m_en && (m_pcnt == int'(m_ps));
        expire   = 0;
        if (lc_write || (wr && adr[3:2] == 2'd0 && wd[0] && !m_en)) m_pcnt = 0;
        else if (tick) m_pcnt = 0;
        else if (m_en) m_pcnt = m_pcnt + 1;
        if (tick && !lc_write) begin
            if (m_count != 0) m_count = m_count - 1;
            else begin
                expire = 1;
                m_exp = 1;
                if (m_auto) m_count = m_load;
                else m_en = 0;
            end
        end
        if (wr) begin
            case (adr[3:2])
                2'd0: begin m_en = wd[0]; m_auto = wd[1]; m_ie = wd[2]; m_ps = wd[15:8]; end
                2'd1: begin m_load = wd; m_count = wd; end
                2'd2: m_count = wd;
                default: if (wd[0] && !expire) m_exp = 0;
            endcase
        end
    endtask

    task automatic step(input logic we, input logic [31:0] adr, input logic [31:0] wd, input logic rst);
        MemWrite = we; DataAdr = adr; WriteData = wd; reset = rst;
        @(posedge clk);
        model_step(we, adr, wd, rst);
        #1;
        MemWrite = 0; reset = 0; WriteData = 0;
    endtask

    task automatic rd(input logic [31:0] adr);
        MemWrite = 0; DataAdr = adr;
        #1;
    endtask

    task automatic test_reset;
        step(0, BASE, 0, 1);
        step(0, BASE, 0, 1);
        for (int o = 0; o < 4; o++) begin
            rd(BASE + 32'(o * 4));
            checks++;
            if (ReadData !== 32'd0) begin
                errors++; $display("FAIL reset_read off=%0d got=%h exp=%h", o * 4, ReadData, 32'd0);
            end
        end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
        rd(32'h0000_1000);
        checks++;
        if (sel !== 1'b0 || ReadData !== 32'd0) begin
            errors++; $display("FAIL outside_read sel=%b data=%h exp sel=0 data=0", sel, ReadData);
        end
    endtask

    task automatic test_auto_reload;
        logic [31:0] exp_seq [9];
        exp_seq = '{3, 2, 1, 0, 3, 2, 1, 0, 3};
        step(0, BASE, 0, 1);
        step(1, BASE + 4, 3, 0);
        step(1, BASE, 32'h7, 0);
        for (int k = 0; k < 9; k++) begin
            rd(BASE + 8);
            checks++;
            if (ReadData !== exp_seq[k] || ReadData !== model_read(BASE + 8)) begin
                errors++; $display("FAIL auto_count k=%0d got=%h exp=%h", k, ReadData, exp_seq[k]);
            end
            checks++;
            if (irq !== (k >= 4)) begin
                errors++; $display("FAIL auto_irq k=%0d got=%b exp=%b", k, irq, (k >= 4));
            end
            step(0, BASE + 8, 0, 0);
        end
    endtask

    task automatic test_one_shot;
        step(0, BASE, 0, 1);
        step(1, BASE + 4, 2, 0);
        step(1, BASE, 32'h0000_0401, 0);
        for (int k = 0; k < 15; k++) begin
            rd(BASE + 8);
            checks++;
            if (ReadData !== 32'(2 - k / 5)) begin
                errors++; $display("FAIL oneshot_count k=%0d got=%h exp=%h", k, ReadData, 32'(2 - k / 5));
            end
            rd(BASE + 12);
            checks++;
            if (ReadData !== 32'd0) begin
                errors++; $display("FAIL oneshot_early_status k=%0d got=%h exp=0", k, ReadData);
            end
            step(0, BASE + 8, 0, 0);
        end
        rd(BASE + 12);
        checks++;
        if (ReadData !== 32'd1) begin errors++; $display("FAIL oneshot_expired got=%h exp=1", ReadData); end
        for (int k = 0; k < 7; k++) step(0, BASE, 0, 0);
        rd(BASE);
        checks++;
        if (ReadData !== 32'h0000_0400) begin errors++; $display("FAIL oneshot_ctrl got=%h exp=00000400", ReadData); end
        rd(BASE + 8);
        checks++;
        if (ReadData !== 32'd0) begin errors++; $display("FAIL oneshot_hold got=%h exp=0", ReadData); end
    endtask

    task automatic test_status_clear;
        step(0, BASE, 0, 1);
        step(1, BASE + 4, 1, 0);
        step(1, BASE, 32'h5, 0);
        step(0, BASE, 0, 0);
        step(1, BASE + 12, 1, 0);
        rd(BASE + 12);
        checks++;
        if (ReadData !== 32'd1 || irq !== 1'b1) begin
            errors++; $display("FAIL status_clear_on_expiry status=%h irq=%b exp status=1 irq=1", ReadData, irq);
        end
        step(1, BASE + 12, 32'hFFFF_FFFE, 0);
        rd(BASE + 12);
        checks++;
        if (ReadData !== 32'd1) begin errors++; $display("FAIL status_write0 got=%h exp=1", ReadData); end
        step(1, BASE + 12, 1, 0);
        rd(BASE + 12);
        checks++;
        if (ReadData !== 32'd0 || irq !== 1'b0) begin
            errors++; $display("FAIL status_clear status=%h irq=%b exp status=0 irq=0", ReadData, irq);
        end
    endtask

    task automatic test_write_priority;
        logic [31:0] held;
        step(0, BASE, 0, 1);
        step(1, BASE + 4, 32'h20, 0);
        step(1, BASE, 32'h1, 0);
        step(0, BASE, 0, 0);
        step(0, BASE, 0, 0);
        step(1, BASE + 8, 32'h10, 0);
        rd(BASE + 8);
        checks++;
        if (ReadData !== 32'h10) begin errors++; $display("FAIL count_write_on_tick got=%h exp=10", ReadData); end
        step(1, BASE, 32'h0, 0);
        held = m_count;
        step(1, 32'h0000_0040, 32'hDEAD_BEEF, 0);
        step(1, 32'h0000_0044, 32'h0000_0007, 0);
        rd(BASE + 8);
        checks++;
        if (ReadData !== held || held !== 32'h0F) begin
            errors++; $display("FAIL outside_store_count got=%h exp=%h", ReadData, 32'h0F);
        end
        rd(BASE + 4);
        checks++;
        if (ReadData !== 32'h20) begin errors++; $display("FAIL outside_store_load got=%h exp=20", ReadData); end
        rd(BASE);
        checks++;
        if (ReadData !== 32'h0) begin errors++; $display("FAIL outside_store_ctrl got=%h exp=0", ReadData); end
    endtask

    task automatic test_reset_midcount;
        step(0, BASE, 0, 1);
        step(1, BASE, 32'h0000_0A05, 0);
        step(1, BASE + 4, 7, 0);
        rd(BASE + 8);
        checks++;
        if (ReadData !== 32'd7) begin errors++; $display("FAIL midcount_setup got=%h exp=7", ReadData); end
        step(1, BASE + 8, 32'h55, 1);
        for (int o = 0; o < 4; o++) begin
            rd(BASE + 32'(o * 4));
            checks++;
            if (ReadData !== 32'd0) begin
                errors++; $display("FAIL midcount_reset off=%0d got=%h exp=0", o * 4, ReadData);
            end
        end
        for (int k = 0; k < 24; k++) step(0, BASE, 0, 0);
        rd(BASE + 12);
        checks++;
        if (ReadData !== 32'd0 || irq !== 1'b0) begin
            errors++; $display("FAIL midcount_no_ticks status=%h irq=%b exp 0 0", ReadData, irq);
        end
    endtask

    task automatic test_random;
        logic        we, rst;
        logic [31:0] adr, wd, radr;
        int          op;
        step(0, BASE, 0, 1);
        for (int n = 0; n < 600; n++) begin
            op  = int'($urandom_range(0, 99));
            rst = (op < 2);
            we  = (op >= 2 && op < 60);
            adr = BASE | ($urandom & 32'hF);
            wd  = $urandom;
            if (op >= 60 && op < 70) adr = (op < 65) ? (BASE + 32'h10) | ($urandom & 32'hF) : 32'h0000_0040;
            case (adr[3:2])
                2'd0: wd = (wd & 32'hFFFF_03FF);
                2'd1, 2'd2: wd = 32'($urandom_range(0, 6));
                default: ;
            endcase
            if (op >= 60 && op < 70) we = 1;
            radr = we ? adr : (BASE | ($urandom & 32'hF));
            MemWrite = we; DataAdr = radr; WriteData = wd; reset = rst;
            #1;
            checks++;
            if (ReadData !== model_read(radr) || sel !== (radr[31:4] == BASE[31:4]) || irq !== (m_exp & m_ie)) begin
                errors++;
                $display("FAIL random n=%0d adr=%h data=%h exp=%h sel=%b irq=%b exp_irq=%b",
                         n, radr, ReadData, model_read(radr), sel, irq, m_exp & m_ie);
            end
            @(posedge clk);
            model_step(we, radr, wd, rst);
            #1;
        end
        MemWrite = 0; reset = 0;
    endtask

    initial begin
        reset = 1; MemWrite = 0; DataAdr = 0; WriteData = 0;
        m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0; m_ps = 0;
        m_load = 0; m_count = 0; m_pcnt = 0;
        test_reset();
        test_auto_reload();
        test_one_shot();
        test_status_clear();
        test_write_priority();
        test_reset_midcount();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped down-counting timer on the processor data bus, beside `dmem`. Decodes a 16-byte window on the data address. Accepts stores through the same write-enable, address and write-data signals that `dmem` sees, and returns load data combinationally. Provides a prescaled countdown with one-shot or auto-reload modes, a sticky expiry flag and an interrupt line. The top level selects between `dmem` read data and this block's read data using `sel`.

## Interface
Parameters:
- `BASE`, 32'hFFFF_0000, window base address; bits [3:0] must be zero.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `MemWrite`  in  1  data-bus store strobe.
- `DataAdr`  in  32  data-bus byte address.
- `WriteData`  in  32  store data.
- `ReadData`  out  32  register read data; 0 when `sel`=0.
- `sel`  out  1  `DataAdr[31:4] == BASE[31:4]`; combinational.
- `irq`  out  1  `EXPIRED & IRQ_EN`.

## Operation
Register map, by offset `DataAdr[3:2]`. `DataAdr[1:0]` is ignored, and all accesses are full 32-bit.
- 0x0 CTRL: bit0 EN, bit1 AUTO, bit2 IRQ_EN, bits[15:8] PRESCALE. All other bits read 0 and are not stored.
- 0x4 LOAD: 32-bit reload value. A write also sets COUNT to the written value and clears the prescaler.
- 0x8 COUNT: reads the current count. A write sets COUNT directly and clears the prescaler.
- 0xC STATUS: bit0 EXPIRED, sticky. Writing 1 to bit0 clears it; writing 0 has no effect.

Write decode and prescaler:
- A write is effective when `MemWrite & sel`. Writes outside the window are ignored.
- Prescaler: 8-bit `pcnt`, advances only while EN=1.
  - When `pcnt == PRESCALE`: `pcnt` returns to 0 and a one-cycle `tick` is generated.
  - Otherwise: `pcnt` increments.
  - With PRESCALE=0, a tick occurs every cycle.

On each `tick`:
- If COUNT != 0: COUNT decrements by 1.
- If COUNT == 0 (expiry): EXPIRED is set to 1.
  - If AUTO=1, COUNT reloads from LOAD.
  - If AUTO=0, EN clears to 0 (one-shot stop).
- Auto-reload period is (LOAD+1)·(PRESCALE+1) cycles between expiries.

Write effects on the prescaler:
- A CTRL write taking EN from 0 to 1 clears `pcnt`.
- A CTRL write with EN=0 holds `pcnt` and COUNT frozen.

Simultaneous events:
- A bus write to COUNT or LOAD in the same cycle as a tick takes priority: COUNT takes the written value and the tick is discarded.
- A CTRL write in the same cycle as a one-shot expiry takes priority for EN. EXPIRED still sets.
- A STATUS clear in the same cycle as an expiry leaves EXPIRED=1 (set wins).
- COUNT arithmetic is 32-bit unsigned. Decrement never wraps, because 0 is handled as expiry.

## Timing
- Reads are combinational: `ReadData` is valid in the same cycle as `DataAdr`, matching the single-cycle `dmem` read path.
- Writes take effect at the rising edge ending the store cycle. A load in the following cycle returns the new value.
- EXPIRED rises on the edge at which the expiring tick is taken. `irq` follows combinationally in the same cycle.
- Reset values: CTRL=0, LOAD=0, COUNT=0, EXPIRED=0, `pcnt`=0, so `irq`=0. `sel` and `ReadData` remain address-driven during reset.
- Reset asserted mid-count clears all state at the next edge; any write in that cycle is discarded.

## Structure
- `mmio_pkg` holds `BASE` default, register offsets (`TMR_CTRL`, `TMR_LOAD`, `TMR_COUNT`, `TMR_STATUS`), CTRL bit indices, and the PRESCALE field range. Future MMIO peripherals reuse it.
- Sub-module `timer_prescaler` holds the 8-bit counter. Inputs: `en`, `clr`, `prescale`. Output: `tick`.
- Register file, decode and COUNT/EXPIRED logic live in `mmio_timer`.

## Test plan
- Reset, then read all four offsets → all return 0; `irq`=0. Read 0x1000 → `sel`=0, `ReadData`=0.
- Write LOAD=3, then CTRL=0x0000_0007 (PRESCALE=0, AUTO, IRQ_EN, EN) → COUNT reads 3,2,1,0 on successive cycles. EXPIRED and `irq` rise 4 cycles after the EN write edge. COUNT reloads to 3, and the period is 4 cycles.
- One-shot with PRESCALE=4 (CTRL=0x0000_0401), LOAD=2 → COUNT decrements every 5 cycles. Expiry occurs at cycle 15, then EN reads 0 and COUNT holds 0.
- Write STATUS=1 in the exact expiry cycle → EXPIRED remains 1. A STATUS=1 write on a later cycle → EXPIRED=0 and `irq`=0.
- Write COUNT=0x10 on a tick cycle → COUNT reads 0x10, not 0x0F. A store to 0x0000_0040 with `MemWrite`=1 → no timer register changes.
- Assert `reset` for one cycle while COUNT=7 and EN=1 → all registers read 0 afterwards and no further ticks occur.
